// File: rtl/hms_pkg.sv
// rtl/hms_pkg.sv - shared states, BCD constants and digit helpers for the h:m:s counter
package hms_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } hms_state_t;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [3:0] BCD_9  = 4'h9;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= BCD_9;
    endfunction

    // One BCD increment of a two-digit value that wraps to 00 after max.
    function automatic logic [7:0] bcd_step(input logic [7:0] q, input logic [7:0] max);
        logic [7:0] r;
        if (q == max)
            r = 8'h00;
        else if (q[3:0] == BCD_9)
            r = {q[7:4] + 4'd1, 4'h0};
        else
            r = {q[7:4], q[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_hms_counter_if.sv
// rtl/bcd_hms_counter_if.sv - preset-load handshake between a requester and the h:m:s counter
interface bcd_hms_counter_if;

    logic        set_req;
    logic [23:0] set_value;
    logic        set_ack;
    logic        set_err;

    modport master (
        output set_req,
        output set_value,
        input  set_ack,
        input  set_err
    );

    modport slave (
        input  set_req,
        input  set_value,
        output set_ack,
        output set_err
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping after MAX, with load and clear
module bcd_mod_counter
    import hms_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    output logic [7:0] q,
    output logic       carry
);

    // Carry is combinational so the next stage advances in the same cycle.
    assign carry = inc && (q == MAX);

    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= 8'h00;
        else if (load)
            q <= load_val;
        else if (inc)
            q <= bcd_step(q, MAX);
    end

endmodule

// File: rtl/bcd_hms_counter.sv
// rtl/bcd_hms_counter.sv - BCD hh:mm:ss counter with run/pause/clear and preset load; ALARM_EN adds an alarm compare
module bcd_hms_counter
    import hms_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = 8'h23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_1s,
    input  logic                    start_stop,
    input  logic                    clear,
    bcd_hms_counter_if.slave        set_bus,
    output logic [7:0]              sec,
    output logic [7:0]              min,
    output logic [7:0]              hour,
    output logic                    running,
    output logic                    wrap
`ifdef ALARM_EN
    ,
    input  logic [23:0]             alarm_value,
    output logic                    alarm
`endif
);

    hms_state_t state_q, state_d;

    logic       tick_1s_d;
    logic       tick_ev;
    logic       set_armed;
    logic       set_fire;
    logic       set_ok;
    logic       set_load;
    logic       count_inc;
    logic       sec_carry, min_carry, hour_carry;
    logic [7:0] set_hh, set_mm, set_ss;

    assign {set_hh, set_mm, set_ss} = set_bus.set_value;

    assign tick_ev = tick_1s & ~tick_1s_d;

    // A request is served once; set_armed re-opens only after set_req is seen low.
    assign set_fire = set_bus.set_req & set_armed & ~clear;

    assign set_ok = (state_q != RUN)
                 && bcd_digit_ok(set_hh[7:4]) && bcd_digit_ok(set_hh[3:0])
                 && bcd_digit_ok(set_mm[7:4]) && bcd_digit_ok(set_mm[3:0])
                 && bcd_digit_ok(set_ss[7:4]) && bcd_digit_ok(set_ss[3:0])
                 && (set_ss <= BCD_59) && (set_mm <= BCD_59) && (set_hh <= HOUR_MAX);

    assign set_load = set_fire & set_ok;

    assign count_inc = tick_ev & (state_q == RUN) & ~clear & ~start_stop & ~set_load;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            tick_1s_d       <= 1'b0;
            set_armed       <= ~set_bus.set_req;
            running         <= 1'b0;
            set_bus.set_ack <= 1'b0;
            set_bus.set_err <= 1'b0;
            wrap            <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_1s_d       <= tick_1s;
            running         <= (state_d == RUN);
            set_bus.set_ack <= set_load;
            set_bus.set_err <= set_fire & ~set_ok;
            wrap            <= hour_carry;
            if (clear)
                set_armed <= ~set_bus.set_req;
            else if (set_fire)
                set_armed <= 1'b0;
            else if (!set_bus.set_req)
                set_armed <= 1'b1;
        end
    end

    bcd_mod_counter #(.MAX(BCD_59)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .load     (set_load),
        .load_val (set_ss),
        .inc      (count_inc),
        .q        (sec),
        .carry    (sec_carry)
    );

    bcd_mod_counter #(.MAX(BCD_59)) u_min (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .load     (set_load),
        .load_val (set_mm),
        .inc      (sec_carry),
        .q        (min),
        .carry    (min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .load     (set_load),
        .load_val (set_hh),
        .inc      (min_carry),
        .q        (hour),
        .carry    (hour_carry)
    );

`ifdef ALARM_EN
    // Compare against the value the counters are about to take, so only ticks can fire it.
    logic [23:0] count_next;

    always_comb begin
        count_next = {min_carry ? bcd_step(hour, HOUR_MAX) : hour,
                      sec_carry ? bcd_step(min, BCD_59)    : min,
                      bcd_step(sec, BCD_59)};
    end

    always_ff @(posedge clk) begin
        if (reset)
            alarm <= 1'b0;
        else
            alarm <= count_inc && (count_next == alarm_value);
    end
`endif

endmodule

// File: doc/bcd_hms_counter.md
# bcd_hms_counter

Downstream of the millisecond BCD counter. Consumes its one-second tick and keeps a BCD hours:minutes:seconds count with run, pause and clear control, plus a validated preset-load handshake. Its outputs, together with the upstream millisecond digits, feed the seven-segment display multiplexer.

## Interface
- HOUR_MAX, 8'h23, BCD value of the last hour before wrap to 00; legal values are 8'h01..8'h99.
- clk  in  1  system clock, same domain as the millisecond counter.
- reset  in  1  synchronous, active-high.
- tick_1s  in  1  one-second tick from upstream; only its rising edge counts.
- start_stop  in  1  one-cycle pulse; toggles between running and paused.
- clear  in  1  one-cycle pulse; zeroes the count and stops.
- set_req  in  1  preset-load request, held until acknowledged or rejected.
- set_value  in  24  BCD {hh, mm, ss}; sampled while set_req is high.
- set_ack  out  1  one-cycle pulse; preset accepted.
- set_err  out  1  one-cycle pulse; preset rejected.
- sec  out  8  BCD seconds, 00-59.
- min  out  8  BCD minutes, 00-59.
- hour  out  8  BCD hours, 00-HOUR_MAX.
- running  out  1  high in the RUN state.
- wrap  out  1  one-cycle pulse when the count rolls from HOUR_MAX:59:59 to 00:00:00.

## Operation
- States: IDLE (count zero, stopped), RUN and PAUSE.
  - IDLE: start_stop goes to RUN.
  - RUN: start_stop goes to PAUSE.
  - PAUSE: start_stop goes to RUN.
  - Any state: clear goes to IDLE and zeroes the count.
- Tick detection: register tick_1s_d. A tick event is tick_1s & ~tick_1s_d. A tick held high for many cycles counts once.
- The count increments only on a tick event in RUN. Tick events in IDLE or PAUSE are dropped, not queued.
- Increment digit by digit:
  - Seconds low digit 9 goes to 0 and carries into the high digit.
  - sec 59 goes to 00 and carries into minutes; min 59 goes to 00 and carries into hours.
  - hour == HOUR_MAX goes to 00 and pulses wrap.
  - Hours carry from 9 into the tens digit as usual.
- Preset:
  - Accepted only in IDLE or PAUSE, and only when every nibble is at most 9, ss ≤ 59, mm ≤ 59 and hh ≤ HOUR_MAX.
  - When accepted, load the count and pulse set_ack; the state is unchanged, so a preset from IDLE stays in IDLE with a nonzero count.
  - Otherwise pulse set_err and leave the count unchanged.
  - One response per request. After responding, ignore set_req until it has been seen low for at least one cycle.
- Priority within a cycle: reset > clear > set > start_stop > tick.
  - clear together with anything else: clear wins; the others are discarded.
  - Accepted set together with start_stop: the load happens, and the state toggle also happens in the same cycle.
  - start_stop together with a tick in RUN: the move to PAUSE wins and the tick is dropped.
  - start_stop together with a tick in PAUSE: the move to RUN happens and the tick is dropped.
- A set_req pending at reset or clear is discarded. No set_ack or set_err is issued for it; the requester must deassert and retry.

## Timing
- All outputs are registered.
- Reset values:
  - sec, min and hour are 0; state is IDLE.
  - running, set_ack, set_err and wrap are 0; tick_1s_d is 0.
- Tick latency:
  - With the tick edge sampled at cycle N, the new count is visible at N+1.
  - wrap is high during N+1 only.
- start_stop at cycle N: running changes at N+1.
- clear at cycle N: the count is zero and running is low at N+1.
- Set handshake:
  - set_req first seen high at N: set_ack or set_err is high at N+1 for exactly one cycle.
  - An accepted value is visible at N+1.
- Throughput: one tick event per two cycles at most, because a rising edge needs a low cycle between events.

## Configuration
- ALARM_EN defined:
  - Adds input alarm_value [23:0] (BCD hh:mm:ss) and output alarm (1 bit, reset 0).
  - alarm pulses for one cycle, at N+1, when a tick-driven increment at N produces a count equal to alarm_value.
  - Preset loads never fire the alarm.
- ALARM_EN undefined: the port and the compare logic are absent; the rest of the behaviour is identical.

## Structure
- Shared package hms_pkg holds:
  - the state enum (IDLE, RUN, PAUSE);
  - BCD constants for 59 and 9;
  - a BCD-digit validity function.
- Sub-module bcd_mod_counter: one two-digit BCD counter with a MAX parameter.
  - Ports inc, load, load_val, clr; outputs q[7:0], carry.
  - Instantiated three times, for seconds, minutes and hours.
- The top level holds the state machine, tick edge detect, set handshake and optional alarm.

## Test plan
- Reset, then start_stop, then 60 tick pulses → sec=00, min=01, hour=00; running=1; no wrap.
- Preset 23:59:58 from PAUSE, then RUN and 2 ticks → set_ack on the first cycle; the second tick gives 00:00:00 with a one-cycle wrap.
- Preset 24:00:00, 12:60:00 or 12:0A:00, and any preset while in RUN → set_err pulse each time; count unchanged.
- tick_1s held high 10 cycles in RUN → exactly one increment. Ticks in PAUSE → no change.
- Simultaneous events:
  - clear with a tick and start_stop → 00:00:00, IDLE.
  - start_stop with a tick in RUN → PAUSE, count unchanged.
- ALARM_EN: alarm_value 00:00:05 → alarm pulses on the fifth tick only. Preset 00:00:05 → no alarm.
